// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32 pipeline: funct3 load/store sizes,
// writeback result sources and register-index width.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read.
// Contents have no reset.
module data_mem #(
    parameter int unsigned MEM_WORD_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [MEM_WORD_BITS-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] r_mem [2**MEM_WORD_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the RV32 pipeline: data memory access with lane select,
// load extension and fault detection, followed by the MEM->WB register.
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_WORD_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    write_dataM_i,
    input  logic [REG_IDX_W-1:0]     rdM_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4M_i,
    input  logic [2:0]               funct3M_i,
    input  logic                     reg_writeM_i,
    input  logic [1:0]               result_srcM_i,
    input  logic                     mem_writeM_i,
    output logic [DATA_WIDTH-1:0]    read_dataW_o,
    output logic [ADDRESS_WIDTH-1:0] alu_resultW_o,
    output logic [REG_IDX_W-1:0]     rdW_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4W_o,
    output logic                     reg_writeW_o,
    output logic [1:0]               result_srcW_o,
    output logic                     faultW_o
);

    logic [MEM_WORD_BITS-1:0] w_word_idx;
    logic [1:0]               w_lane;
    logic                     w_is_load;
    logic                     w_is_store;
    logic                     w_misaligned;
    logic                     w_ld_illegal;
    logic                     w_st_illegal;
    logic                     w_fault;
    logic                     w_we;
    logic [3:0]               w_be;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_rword;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic                     w_unused_addr;

    logic [DATA_WIDTH-1:0]    r_read_data;
    logic [ADDRESS_WIDTH-1:0] r_alu_result;
    logic [REG_IDX_W-1:0]     r_rd;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;
    logic                     r_reg_write;
    logic [1:0]               r_result_src;
    logic                     r_fault;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign w_word_idx    = alu_resultM_i[MEM_WORD_BITS+1:2];
    assign w_lane        = alu_resultM_i[1:0];
    assign w_unused_addr = ^alu_resultM_i[ADDRESS_WIDTH-1:MEM_WORD_BITS+2];

    assign w_is_load  = (result_srcM_i == RES_MEM);
    assign w_is_store = mem_writeM_i;

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3M_i[1:0])
            2'b01:   w_misaligned = w_lane[0];
            2'b10:   w_misaligned = (w_lane != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_ld_illegal = funct3M_i inside {3'b011, 3'b110, 3'b111};
    assign w_st_illegal = !(funct3M_i inside {F3_B, F3_H, F3_W});

    assign w_fault = (w_is_store && (w_st_illegal || w_misaligned)) ||
                     (w_is_load  && (w_ld_illegal || w_misaligned));

    // Reset blocks any commit, including a store presented in the same cycle.
    assign w_we = en_i && w_is_store && !w_fault && !rst_i;

    always_comb begin
        w_be    = '0;
        w_wdata = write_dataM_i;
        case (funct3M_i)
            F3_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{write_dataM_i[7:0]}};
            end
            F3_H: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_dataM_i[15:0]}};
            end
            F3_W: begin
                w_be    = 4'b1111;
                w_wdata = write_dataM_i;
            end
            default: begin
                w_be    = '0;
                w_wdata = write_dataM_i;
            end
        endcase
    end

    data_mem #(
        .MEM_WORD_BITS(MEM_WORD_BITS)
    ) u_data_mem (
        .clk_i  (clk_i),
        .we_i   (w_we),
        .be_i   (w_be),
        .addr_i (w_word_idx),
        .wdata_i(w_wdata),
        .rdata_o(w_rword)
    );

    always_comb begin
        w_byte = w_rword[7:0];
        case (w_lane)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
    end

    always_comb begin
        w_load_data = '0;
        if (!w_fault) begin
            case (funct3M_i)
                F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
                F3_BU:   w_load_data = {24'd0, w_byte};
                F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
                F3_HU:   w_load_data = {16'd0, w_half};
                F3_W:    w_load_data = w_rword;
                default: w_load_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_reg_write  <= 1'b0;
            r_result_src <= '0;
            r_fault      <= 1'b0;
        end else if (en_i) begin
            r_read_data  <= w_load_data;
            r_alu_result <= alu_resultM_i;
            r_rd         <= rdM_i;
            r_pc_plus4   <= pc_plus4M_i;
            r_reg_write  <= reg_writeM_i && !(w_fault && w_is_load);
            r_result_src <= result_srcM_i;
            r_fault      <= w_fault;
        end
    end

    assign read_dataW_o  = r_read_data;
    assign alu_resultW_o = r_alu_result;
    assign rdW_o         = r_rd;
    assign pc_plus4W_o   = r_pc_plus4;
    assign reg_writeW_o  = r_reg_write;
    assign result_srcW_o = r_result_src;
    assign faultW_o      = r_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, reset/stall sequences and
// random instructions checked against a byte-array reference model.
module tb_mem_wb_stage;
    import pipeline_pkg::*;

    localparam int unsigned MEM_BYTES = 4096;

    typedef struct {
        bit          en;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [2:0]  f3;
        bit          rw;
        logic [1:0]  rs;
        bit          mw;
    } in_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rw;
        logic [1:0]  rs;
        logic        fault;
    } out_t;

    typedef struct {
        in_t         in;
        logic [31:0] rdata;
        bit          fault;
        bit          rw;
        bit          chk_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] alu_m, wd_m, pc4_m;
    logic [4:0]  rd_m;
    logic [2:0]  f3_m;
    logic        rw_m, mw_m;
    logic [1:0]  rs_m;

    logic [31:0] read_dataW, alu_resultW, pc_plus4W;
    logic [4:0]  rdW;
    logic        reg_writeW, faultW;
    logic [1:0]  result_srcW;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [MEM_BYTES];
    out_t       exp_o;
    bit         exp_rd_chk;
    vec_t       vecs [$];

    always #5 clk = ~clk;

    mem_wb_stage #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .MEM_WORD_BITS(10)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .alu_resultM_i(alu_m),
        .write_dataM_i(wd_m),
        .rdM_i        (rd_m),
        .pc_plus4M_i  (pc4_m),
        .funct3M_i    (f3_m),
        .reg_writeM_i (rw_m),
        .result_srcM_i(rs_m),
        .mem_writeM_i (mw_m),
        .read_dataW_o (read_dataW),
        .alu_resultW_o(alu_resultW),
        .rdW_o        (rdW),
        .pc_plus4W_o  (pc_plus4W),
        .reg_writeW_o (reg_writeW),
        .result_srcW_o(result_srcW),
        .faultW_o     (faultW)
    );

    function automatic in_t mk(bit e, logic [31:0] a, logic [31:0] d, logic [4:0] r,
                               logic [31:0] p, logic [2:0] f, bit w, logic [1:0] s, bit m);
        in_t x;
        x.en = e; x.alu = a; x.wd = d; x.rd = r; x.pc4 = p;
        x.f3 = f; x.rw = w; x.rs = s; x.mw = m;
        return x;
    endfunction

    function automatic void add_vec(in_t x, logic [31:0] rdata, bit fault, bit rw, bit chk_rd);
        vec_t v;
        v.in = x; v.rdata = rdata; v.fault = fault; v.rw = rw; v.chk_rd = chk_rd;
        vecs.push_back(v);
    endfunction

    // Reference: memory is a flat byte array; an access touches 1, 2 or 4
    // consecutive bytes starting at the byte address modulo the memory size.
    function automatic void model_step(in_t x);
        int unsigned n, ba;
        bit          ld_legal, st_legal, mis, fault, is_load;
        logic [31:0] v;
        if (!x.en) return;
        n        = 1 << x.f3[1:0];
        ba       = x.alu % MEM_BYTES;
        ld_legal = (x.f3 == 3'd0) || (x.f3 == 3'd1) || (x.f3 == 3'd2) ||
                   (x.f3 == 3'd4) || (x.f3 == 3'd5);
        st_legal = (x.f3 <= 3'd2);
        mis      = (n == 2 && (x.alu % 2) != 0) || (n == 4 && (x.alu % 4) != 0);
        is_load  = (x.rs == 2'b01);
        fault    = (x.mw && (!st_legal || mis)) || (is_load && (!ld_legal || mis));

        v = 0;
        if (ld_legal && !mis) begin
            for (int unsigned k = 0; k < n; k++)
                v = v | (32'(ref_mem[(ba + k) % MEM_BYTES]) << (8 * k));
            if (!x.f3[2] && n < 4 && v[8*n-1])
                v = v | ~((32'd1 << (8 * n)) - 32'd1);
        end
        exp_o.rdata = fault ? 32'd0 : v;
        exp_rd_chk  = fault || (ld_legal && !mis);
        exp_o.alu   = x.alu;
        exp_o.rd    = x.rd;
        exp_o.pc4   = x.pc4;
        exp_o.rw    = x.rw && !(fault && is_load);
        exp_o.rs    = x.rs;
        exp_o.fault = fault;

        if (x.mw && !fault)
            for (int unsigned k = 0; k < n; k++)
                ref_mem[(ba + k) % MEM_BYTES] = x.wd[8*k +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_model(input string tag);
        if (exp_rd_chk) chk({tag, ".rdata"}, read_dataW, exp_o.rdata);
        chk({tag, ".alu"},   alu_resultW,        exp_o.alu);
        chk({tag, ".rd"},    32'(rdW),           32'(exp_o.rd));
        chk({tag, ".pc4"},   pc_plus4W,          exp_o.pc4);
        chk({tag, ".rw"},    32'(reg_writeW),    32'(exp_o.rw));
        chk({tag, ".rs"},    32'(result_srcW),   32'(exp_o.rs));
        chk({tag, ".fault"}, 32'(faultW),        32'(exp_o.fault));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rdata"}, read_dataW,       32'd0);
        chk({tag, ".alu"},   alu_resultW,      32'd0);
        chk({tag, ".rd"},    32'(rdW),         32'd0);
        chk({tag, ".pc4"},   pc_plus4W,        32'd0);
        chk({tag, ".rw"},    32'(reg_writeW),  32'd0);
        chk({tag, ".rs"},    32'(result_srcW), 32'd0);
        chk({tag, ".fault"}, 32'(faultW),      32'd0);
    endtask

    task automatic drive(input in_t x);
        en = x.en; alu_m = x.alu; wd_m = x.wd; rd_m = x.rd; pc4_m = x.pc4;
        f3_m = x.f3; rw_m = x.rw; rs_m = x.rs; mw_m = x.mw;
    endtask

    task automatic step(input in_t x, input string tag);
        @(negedge clk);
        drive(x);
        @(posedge clk);
        #1;
        model_step(x);
        check_model(tag);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        logic [1:0]  s;
        bit          m, e;

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_o = '{default: '0};
        exp_rd_chk = 1'b1;
        #12;
        check_zero("por");
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < MEM_BYTES / 4; i++)
            step(mk(1, i * 4, $urandom, 5'd0, 32'd4, F3_W, 0, RES_ALU, 1), "preload");

        // Reset mid-cycle with a live store to 0x10
        step(mk(1, 32'h1234, 32'h5678, 5'd9, 32'h400, F3_W, 1, RES_ALU, 0), "pre_rst");
        @(negedge clk);
        drive(mk(1, 32'h10, 32'hDEADBEEF, 5'd31, 32'h804, F3_W, 1, RES_PC4, 1));
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_held");
        @(negedge clk);
        en = 1'b0; mw_m = 1'b0; rst = 1'b0;
        exp_o = '{default: '0};
        exp_rd_chk = 1'b1;
        step(mk(1, 32'h10, 0, 5'd3, 32'h14, F3_W, 1, RES_MEM, 0), "rst_nocommit");
        chk("rst_nocommit.not_new", 32'(read_dataW == 32'hDEADBEEF), 32'd0);

        // Directed vector table
        add_vec(mk(1, 32'h20, 32'h11223344, 5'd1, 32'h4, F3_W, 0, RES_ALU, 1), 0, 0, 0, 0);
        add_vec(mk(1, 32'h21, 32'h000000AA, 5'd2, 32'h8, F3_B, 0, RES_ALU, 1), 0, 0, 0, 0);
        add_vec(mk(1, 32'h22, 32'h0000BEEF, 5'd3, 32'hC, F3_H, 0, RES_ALU, 1), 0, 0, 0, 0);
        add_vec(mk(1, 32'h20, 0, 5'd4, 32'h10, F3_W, 1, RES_MEM, 0), 32'hBEEFAA44, 0, 1, 1);
        add_vec(mk(1, 32'h20, 32'h8081F0FF, 5'd5, 32'h14, F3_W, 0, RES_ALU, 1), 0, 0, 0, 0);
        add_vec(mk(1, 32'h20, 0, 5'd6, 32'h18, F3_B, 1, RES_MEM, 0), 32'hFFFFFFFF, 0, 1, 1);
        add_vec(mk(1, 32'h21, 0, 5'd7, 32'h1C, F3_BU, 1, RES_MEM, 0), 32'h000000F0, 0, 1, 1);
        add_vec(mk(1, 32'h22, 0, 5'd8, 32'h20, F3_H, 1, RES_MEM, 0), 32'hFFFF8081, 0, 1, 1);
        add_vec(mk(1, 32'h22, 0, 5'd9, 32'h24, F3_HU, 1, RES_MEM, 0), 32'h00008081, 0, 1, 1);
        add_vec(mk(1, 32'h22, 0, 5'd10, 32'h28, F3_W, 1, RES_MEM, 0), 32'h0, 1, 0, 1);
        add_vec(mk(1, 32'h23, 32'h1234, 5'd11, 32'h2C, F3_H, 0, RES_ALU, 1), 32'h0, 1, 0, 1);
        add_vec(mk(1, 32'h20, 0, 5'd12, 32'h30, F3_W, 1, RES_MEM, 0), 32'h8081F0FF, 0, 1, 1);
        add_vec(mk(1, 32'h20, 0, 5'd13, 32'h34, 3'b011, 1, RES_MEM, 0), 32'h0, 1, 0, 1);
        add_vec(mk(1, 32'h1000, 32'h12345678, 5'd14, 32'h38, F3_W, 0, RES_ALU, 1), 0, 0, 0, 0);
        add_vec(mk(1, 32'h0, 0, 5'd15, 32'h3C, F3_W, 1, RES_MEM, 0), 32'h12345678, 0, 1, 1);
        add_vec(mk(1, 32'h55, 0, 5'd7, 32'h40, F3_W, 1, RES_ALU, 0), 0, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].in, $sformatf("vec%0d", i));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d.rdata_tbl", i), read_dataW, vecs[i].rdata);
            chk($sformatf("vec%0d.fault_tbl", i), 32'(faultW), 32'(vecs[i].fault));
            chk($sformatf("vec%0d.rw_tbl", i), 32'(reg_writeW), 32'(vecs[i].rw));
            chk($sformatf("vec%0d.rd_tbl", i), 32'(rdW), 32'(vecs[i].in.rd));
            chk($sformatf("vec%0d.alu_tbl", i), alu_resultW, vecs[i].in.alu);
        end

        // Stalled store that is then dropped must leave memory untouched
        for (int i = 0; i < 2; i++)
            step(mk(0, 32'h40, 32'h0BADF00D, 5'd1, 32'h4, F3_W, 0, RES_ALU, 1), "stall_drop");
        step(mk(1, 32'h40, 0, 5'd2, 32'h8, F3_W, 1, RES_MEM, 0), "stall_drop_ld");
        chk("stall_drop.not_new", 32'(read_dataW == 32'h0BADF00D), 32'd0);

        // Stall for three cycles, then commit
        for (int i = 0; i < 3; i++)
            step(mk(0, 32'h40, 32'hCAFEBABE, 5'd3, 32'hC, F3_W, 0, RES_ALU, 1), "stall_hold");
        chk("stall_hold.rd", 32'(rdW), 32'd2);
        step(mk(1, 32'h40, 32'hCAFEBABE, 5'd3, 32'hC, F3_W, 0, RES_ALU, 1), "stall_commit");
        step(mk(1, 32'h40, 0, 5'd4, 32'h10, F3_W, 1, RES_MEM, 0), "stall_ld");
        chk("stall_ld.value", read_dataW, 32'hCAFEBABE);

        // Random instruction mix
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) != 0);
            a = $urandom & 32'hF000_307F;
            d = $urandom;
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                3'($urandom_range(0, 2)) | ($urandom_range(0, 1) == 1 ? 3'b100 : 3'b000);
            m = ($urandom_range(0, 2) == 0);
            s = m ? ($urandom_range(0, 1) == 1 ? RES_ALU : RES_PC4) : 2'($urandom);
            if (m && f[2]) f = 3'($urandom_range(0, 7));
            step(mk(e, a, d, 5'($urandom), $urandom, f, 1'($urandom), s, m), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It consumes the EX->MEM register outputs (ALU result, store data, rd, pc+4, control).
- Contains the byte-addressable data memory. Performs stores of byte, half or word, and loads with sign or zero extension.
- Registers everything the writeback stage needs, forming the MEM->WB boundary.
- Flags misaligned and illegal accesses.

Parameters:
- ADDRESS_WIDTH, 32, width of addresses and pc+4.
- DATA_WIDTH, 32, register/data width; fixed at 32 for RV32.
- MEM_WORD_BITS, 10, log2 of the data memory depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- en_i  in  1  stage enable; 0 = stall.
- alu_resultM_i  in  ADDRESS_WIDTH  effective address / ALU result.
- write_dataM_i  in  DATA_WIDTH  store data (rs2).
- rdM_i  in  5  destination register.
- pc_plus4M_i  in  ADDRESS_WIDTH  pc+4.
- funct3M_i  in  3  access size/sign.
- reg_writeM_i  in  1  register write enable.
- result_srcM_i  in  2  00 ALU, 01 memory, 10 pc+4.
- mem_writeM_i  in  1  store enable.
- read_dataW_o  out  DATA_WIDTH  extended load data.
- alu_resultW_o  out  ADDRESS_WIDTH  registered ALU result.
- rdW_o  out  5  registered rd.
- pc_plus4W_o  out  ADDRESS_WIDTH  registered pc+4.
- reg_writeW_o  out  1  registered reg write enable; forced 0 on a faulting load.
- result_srcW_o  out  2  registered result source.
- faultW_o  out  1  misaligned or illegal access occurred.

Behaviour:
- Reset:
  - rst_i high clears all W outputs to 0 immediately, with no clock needed.
  - Memory contents are not cleared.
  - Reset has priority over en_i and over any store in flight; no write commits while rst_i is high.
- Addressing:
  - word index = alu_resultM_i[MEM_WORD_BITS+1:2]; byte lane = alu_resultM_i[1:0].
  - Upper address bits are ignored, so addresses wrap modulo the memory size.
- Store (mem_writeM_i=1, en_i=1, no fault):
  - Written on the rising edge with per-byte enables.
  - SB (000): lane = addr[1:0], data = wd[7:0].
  - SH (001): lanes addr[1]*2 and +1, data = wd[15:0].
  - SW (010): all four lanes.
- Load read path:
  - Read is combinational in M and captured into read_dataW_o at the edge: one-cycle latency from M to W.
  - LB (000) / LBU (100): selected byte, sign- or zero-extended.
  - LH (001) / LHU (101): selected half, sign- or zero-extended.
  - LW (010): full word.
  - read_dataW_o is captured every enabled cycle regardless of result_src.
- Fault conditions (evaluated only when mem_writeM_i=1 or result_srcM_i=01):
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=00.
  - Illegal: load with funct3 in {011,110,111}, or store with funct3 not in {000,001,010}.
- Fault response:
  - Store is suppressed (memory unchanged).
  - read_dataW_o=0.
  - reg_writeW_o=0 for loads.
  - faultW_o=1 for one W cycle.
- Stall: en_i=0 holds every W register and suppresses any store in that cycle. The store commits on the first cycle in which en_i=1.
- Store then load to the same address in the next instruction: the load returns the new data. There is no forwarding hazard, because the write lands at the edge before the load reaches M.
- Non-memory instructions:
  - alu_resultW_o, rdW_o, pc_plus4W_o and result_srcW_o pass through with one-cycle latency.
  - reg_writeW_o follows reg_writeM_i.

Decomposition:
- Package pipeline_pkg:
  - funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - result_src encodings (RES_ALU, RES_MEM, RES_PC4).
  - Register-index width constant (5).
- One sub-module: data_mem, a byte-enable synchronous-write, combinational-read RAM parameterised by MEM_WORD_BITS.
- Lane select, extension and fault logic stay in mem_wb_stage.

Test Plan:
- Reset:
  - Drive all inputs nonzero, pulse rst_i mid-cycle -> all W outputs read 0 before the next edge.
  - A concurrent SW to 0x10 does not commit (later LW 0x10 returns the preloaded value).
- Byte/half stores:
  - SW 0x11223344 at 0x20, then SB 0xAA at 0x21, then SH 0xBEEF at 0x22, then LW 0x20 -> read_dataW_o=0xBEEFAA44.
- Load extension (word 0x20 = 0x8081F0FF):
  - LB 0x20 -> 0xFFFFFFFF.
  - LBU 0x21 -> 0x000000F0.
  - LH 0x22 -> 0xFFFF8081.
  - LHU 0x22 -> 0x00008081.
- Faults:
  - LW 0x22 -> faultW_o=1, reg_writeW_o=0, read_dataW_o=0.
  - SH 0x23 -> memory unchanged, faultW_o=1.
  - Load funct3=011 -> faultW_o=1.
- Stall:
  - SW 0xCAFEBABE at 0x40 with en_i=0 for 3 cycles -> W outputs held and memory unchanged.
  - On en_i=1 -> write commits; the following LW 0x40 returns 0xCAFEBABE.
- Wrap and pass-through:
  - With MEM_WORD_BITS=10, SW 0x12345678 to 0x1000 -> LW 0x0 returns 0x12345678.
  - ALU instruction (result_src=00, rd=7, alu=0x55) -> rdW_o=7, alu_resultW_o=0x55 one cycle later.
